// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory pipeline stage.
// Access-state encoding and load/store funct3 codes.
package riscv_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_REQ,
        MEM_RSP
    } mem_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data memory: store enables/replication,
// load lane extraction with extension, and misalignment detection.
module mem_lane_align
    import riscv_pkg::*;
(
    input  logic [2:0]  req_f3_i,
    input  logic [1:0]  req_off_i,
    input  logic [31:0] store_data_i,
    input  logic [2:0]  rsp_f3_i,
    input  logic [1:0]  rsp_off_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    output logic [31:0] load_data_o
);

    logic [31:0] shifted;

    always_comb begin
        be_o         = 4'hF;
        wdata_o      = store_data_i;
        misaligned_o = 1'b0;
        case (req_f3_i)
            F3_SB, F3_LBU: begin
                be_o    = 4'b0001 << req_off_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            F3_SH, F3_LHU: begin
                be_o         = 4'b0011 << {req_off_i[1], 1'b0};
                wdata_o      = {2{store_data_i[15:0]}};
                misaligned_o = req_off_i[0];
            end
            default: begin
                misaligned_o = (req_off_i != 2'b00);
            end
        endcase
    end

    // Lane 0 of the shifted word holds the addressed byte/half.
    always_comb begin
        shifted     = rdata_i >> {rsp_off_i, 3'b000};
        load_data_o = shifted;
        case (rsp_f3_i)
            F3_LB:   load_data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data_o = {24'h0, shifted[7:0]};
            F3_LHU:  load_data_o = {16'h0, shifted[15:0]};
            F3_LW:   load_data_o = shifted;
            default: load_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// RV32I MEM stage: req/gnt/rvalid data-memory port, lane alignment,
// upstream stall while an access is outstanding, WB registers.
module memory_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [31:0]       instruction_i,
    input  logic [XLEN-1:0]   alu_data_i,
    input  logic [4:0]        rf_addr_i,
    input  logic              rd_write_enable_i,
    input  logic              mem_read_enable_i,
    input  logic              mem_write_enable_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [XLEN-1:0]   mem_wdata_i,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [3:0]        dmem_be_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              valid_o,
    output logic [XLEN-1:0]   rd_data_o,
    output logic [4:0]        rf_addr_o,
    output logic              rd_write_enable_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [31:0]       instruction_o,
    output logic              misaligned_o
);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic              store_q, store_d;
    logic [XLEN-1:0]   lpc_q, lpc_d;
    logic [31:0]       linstr_q, linstr_d;
    logic [4:0]        lrf_q, lrf_d;
    logic              lrdwe_q, lrdwe_d;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;
    logic [4:0]        rf_addr_q, rf_addr_d;
    logic              rd_we_q, rd_we_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              mis_q, mis_d;

    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic              lane_mis;
    logic [31:0]       lane_load;
    logic              is_mem;

    mem_lane_align u_align (
        .req_f3_i     (instruction_i[14:12]),
        .req_off_i    (mem_addr_i[1:0]),
        .store_data_i (mem_wdata_i),
        .rsp_f3_i     (f3_q),
        .rsp_off_i    (addr_q[1:0]),
        .rdata_i      (dmem_rdata_i),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .misaligned_o (lane_mis),
        .load_data_o  (lane_load)
    );

    assign is_mem = mem_read_enable_i | mem_write_enable_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        f3_d      = f3_q;
        store_d   = store_q;
        lpc_d     = lpc_q;
        linstr_d  = linstr_q;
        lrf_d     = lrf_q;
        lrdwe_d   = lrdwe_q;
        valid_d   = 1'b0;
        mis_d     = 1'b0;
        rd_data_d = rd_data_q;
        rf_addr_d = rf_addr_q;
        rd_we_d   = rd_we_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        case (state_q)
            MEM_IDLE: begin
                if (valid_i && is_mem && lane_mis) begin
                    valid_d   = 1'b1;
                    mis_d     = 1'b1;
                    rd_we_d   = 1'b0;
                    rd_data_d = alu_data_i;
                    rf_addr_d = rf_addr_i;
                    pc_d      = pc_i;
                    instr_d   = instruction_i;
                end else if (valid_i && is_mem) begin
                    state_d  = MEM_REQ;
                    addr_d   = mem_addr_i;
                    be_d     = lane_be;
                    wdata_d  = lane_wdata;
                    f3_d     = instruction_i[14:12];
                    store_d  = mem_write_enable_i;
                    lpc_d    = pc_i;
                    linstr_d = instruction_i;
                    lrf_d    = rf_addr_i;
                    lrdwe_d  = rd_write_enable_i;
                end else begin
                    valid_d   = valid_i;
                    rd_data_d = alu_data_i;
                    rf_addr_d = rf_addr_i;
                    rd_we_d   = rd_write_enable_i & valid_i;
                    pc_d      = pc_i;
                    instr_d   = instruction_i;
                end
            end
            MEM_REQ: begin
                if (dmem_gnt_i && store_q) begin
                    state_d   = MEM_IDLE;
                    valid_d   = 1'b1;
                    rd_we_d   = 1'b0;
                    rd_data_d = '0;
                    rf_addr_d = lrf_q;
                    pc_d      = lpc_q;
                    instr_d   = linstr_q;
                end else if (dmem_gnt_i) begin
                    state_d = MEM_RSP;
                end
            end
            MEM_RSP: begin
                if (dmem_rvalid_i) begin
                    state_d   = MEM_IDLE;
                    valid_d   = 1'b1;
                    rd_data_d = lane_load;
                    rd_we_d   = lrdwe_q;
                    rf_addr_d = lrf_q;
                    pc_d      = lpc_q;
                    instr_d   = linstr_q;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= MEM_IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            f3_q      <= '0;
            store_q   <= 1'b0;
            lpc_q     <= '0;
            linstr_q  <= '0;
            lrf_q     <= '0;
            lrdwe_q   <= 1'b0;
            valid_q   <= 1'b0;
            rd_data_q <= '0;
            rf_addr_q <= '0;
            rd_we_q   <= 1'b0;
            pc_q      <= '0;
            instr_q   <= '0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            f3_q      <= f3_d;
            store_q   <= store_d;
            lpc_q     <= lpc_d;
            linstr_q  <= linstr_d;
            lrf_q     <= lrf_d;
            lrdwe_q   <= lrdwe_d;
            valid_q   <= valid_d;
            rd_data_q <= rd_data_d;
            rf_addr_q <= rf_addr_d;
            rd_we_q   <= rd_we_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            mis_q     <= mis_d;
        end
    end

    // Bus fields come straight from the latched request so they hold until gnt.
    assign stall_o           = (state_q != MEM_IDLE);
    assign dmem_req_o        = (state_q == MEM_REQ);
    assign dmem_we_o         = dmem_req_o & store_q;
    assign dmem_be_o         = dmem_req_o ? be_q : 4'h0;
    assign dmem_addr_o       = {addr_q[ADDR_W-1:2], 2'b00};
    assign dmem_wdata_o      = wdata_q;
    assign valid_o           = valid_q;
    assign rd_data_o         = rd_data_q;
    assign rf_addr_o         = rf_addr_q;
    assign rd_write_enable_o = rd_we_q;
    assign pc_o              = pc_q;
    assign instruction_o     = instr_q;
    assign misaligned_o      = mis_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
// Linear stimulus with hand-computed expectations.
module tb_memory_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] pc_i;
    logic [31:0] instruction_i;
    logic [31:0] alu_data_i;
    logic [4:0]  rf_addr_i;
    logic        rd_write_enable_i;
    logic        mem_read_enable_i;
    logic        mem_write_enable_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        valid_o;
    logic [31:0] rd_data_o;
    logic [4:0]  rf_addr_o;
    logic        rd_write_enable_o;
    logic [31:0] pc_o;
    logic [31:0] instruction_o;
    logic        misaligned_o;

    int checks = 0;
    int errors = 0;

    memory_stage dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .valid_i            (valid_i),
        .pc_i               (pc_i),
        .instruction_i      (instruction_i),
        .alu_data_i         (alu_data_i),
        .rf_addr_i          (rf_addr_i),
        .rd_write_enable_i  (rd_write_enable_i),
        .mem_read_enable_i  (mem_read_enable_i),
        .mem_write_enable_i (mem_write_enable_i),
        .mem_addr_i         (mem_addr_i),
        .mem_wdata_i        (mem_wdata_i),
        .stall_o            (stall_o),
        .dmem_req_o         (dmem_req_o),
        .dmem_we_o          (dmem_we_o),
        .dmem_be_o          (dmem_be_o),
        .dmem_addr_o        (dmem_addr_o),
        .dmem_wdata_o       (dmem_wdata_o),
        .dmem_gnt_i         (dmem_gnt_i),
        .dmem_rvalid_i      (dmem_rvalid_i),
        .dmem_rdata_i       (dmem_rdata_i),
        .valid_o            (valid_o),
        .rd_data_o          (rd_data_o),
        .rf_addr_o          (rf_addr_o),
        .rd_write_enable_o  (rd_write_enable_o),
        .pc_o               (pc_o),
        .instruction_o      (instruction_o),
        .misaligned_o       (misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rf,
                         input logic rdwe, input logic [31:0] alu);
        valid_i            = v;
        mem_read_enable_i  = rd;
        mem_write_enable_i = wr;
        instruction_i      = {17'h0, f3, 12'h003};
        pc_i               = 32'h1000 + {27'h0, rf, 2'b00};
        mem_addr_i         = addr;
        mem_wdata_i        = wd;
        rf_addr_i          = rf;
        rd_write_enable_i  = rdwe;
        alu_data_i         = alu;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [31:0] exp);
        drive(1, 1, 0, f3, addr, 0, 5'd7, 1, 32'h0);
        step();
        chk({tag, "_req"}, {31'h0, dmem_req_o}, 1);
        chk({tag, "_we"}, {31'h0, dmem_we_o}, 0);
        chk({tag, "_addr"}, dmem_addr_o, {addr[31:2], 2'b00});
        dmem_gnt_i = 1;
        step();
        dmem_gnt_i = 0;
        chk({tag, "_rsp_stall"}, {31'h0, stall_o}, 1);
        chk({tag, "_rsp_valid"}, {31'h0, valid_o}, 0);
        dmem_rvalid_i = 1;
        dmem_rdata_i  = rdata;
        step();
        dmem_rvalid_i = 0;
        chk({tag, "_valid"}, {31'h0, valid_o}, 1);
        chk({tag, "_data"}, rd_data_o, exp);
        chk({tag, "_rf"}, {27'h0, rf_addr_o}, 7);
        chk({tag, "_rdwe"}, {31'h0, rd_write_enable_o}, 1);
    endtask

    initial begin
        rst_i = 1;
        dmem_gnt_i = 0;
        dmem_rvalid_i = 0;
        dmem_rdata_i = 0;
        drive(0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        step();
        step();
        chk("rst_valid", {31'h0, valid_o}, 0);
        chk("rst_req", {31'h0, dmem_req_o}, 0);
        chk("rst_stall", {31'h0, stall_o}, 0);
        chk("rst_data", rd_data_o, 0);
        rst_i = 0;

        // SW with grant in the second request cycle
        drive(1, 0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 5'd5, 1, 0);
        step();
        chk("sw_req1", {31'h0, dmem_req_o}, 1);
        chk("sw_we", {31'h0, dmem_we_o}, 1);
        chk("sw_be", {28'h0, dmem_be_o}, 32'hF);
        chk("sw_addr", dmem_addr_o, 32'h104);
        chk("sw_wdata", dmem_wdata_o, 32'hDEADBEEF);
        chk("sw_stall", {31'h0, stall_o}, 1);
        chk("sw_bubble", {31'h0, valid_o}, 0);
        step();
        chk("sw_req2", {31'h0, dmem_req_o}, 1);
        chk("sw_addr2", dmem_addr_o, 32'h104);
        dmem_gnt_i = 1;
        step();
        dmem_gnt_i = 0;
        chk("sw_valid", {31'h0, valid_o}, 1);
        chk("sw_rdwe", {31'h0, rd_write_enable_o}, 0);
        chk("sw_req_off", {31'h0, dmem_req_o}, 0);
        chk("sw_pc", pc_o, 32'h1014);

        drive(1, 0, 1, 3'b000, 32'h103, 32'h123456AB, 5'd1, 0, 0);
        step();
        chk("sb_be", {28'h0, dmem_be_o}, 32'h8);
        chk("sb_wdata", dmem_wdata_o, 32'hABABABAB);
        chk("sb_addr", dmem_addr_o, 32'h100);
        dmem_gnt_i = 1;
        step();
        chk("sb_valid", {31'h0, valid_o}, 1);

        drive(1, 0, 1, 3'b001, 32'h106, 32'h0000BEEF, 5'd1, 0, 0);
        step();
        chk("sh_be", {28'h0, dmem_be_o}, 32'hC);
        chk("sh_wdata", dmem_wdata_o, 32'hBEEFBEEF);
        step();
        dmem_gnt_i = 0;
        chk("sh_valid", {31'h0, valid_o}, 1);

        do_load("lb", 3'b000, 32'h102, 32'h00800000, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h102, 32'h00800000, 32'h00000080);
        do_load("lhu", 3'b101, 32'h102, 32'h80011234, 32'h00008001);
        do_load("lh", 3'b001, 32'h100, 32'h12348001, 32'hFFFF8001);

        drive(1, 1, 0, 3'b010, 32'h101, 0, 5'd3, 1, 32'h0);
        step();
        chk("mis_req", {31'h0, dmem_req_o}, 0);
        chk("mis_valid", {31'h0, valid_o}, 1);
        chk("mis_flag", {31'h0, misaligned_o}, 1);
        chk("mis_rdwe", {31'h0, rd_write_enable_o}, 0);
        chk("mis_stall", {31'h0, stall_o}, 0);
        drive(0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        step();
        chk("mis_clear", {31'h0, misaligned_o}, 0);
        chk("idle_valid", {31'h0, valid_o}, 0);

        // LW with late rvalid, followed by ADD
        drive(1, 1, 0, 3'b010, 32'h200, 0, 5'd8, 1, 32'h0);
        step();
        chk("lw_stall_req", {31'h0, stall_o}, 1);
        dmem_gnt_i = 1;
        step();
        dmem_gnt_i = 0;
        for (int i = 0; i < 3; i++) begin
            chk("lw_stall_wait", {31'h0, stall_o}, 1);
            chk("lw_bubble", {31'h0, valid_o}, 0);
            step();
        end
        chk("lw_stall_last", {31'h0, stall_o}, 1);
        dmem_rvalid_i = 1;
        dmem_rdata_i  = 32'h11223344;
        step();
        dmem_rvalid_i = 0;
        chk("lw_valid", {31'h0, valid_o}, 1);
        chk("lw_data", rd_data_o, 32'h11223344);
        chk("lw_rf", {27'h0, rf_addr_o}, 8);
        chk("lw_stall_done", {31'h0, stall_o}, 0);
        drive(1, 0, 0, 3'b000, 0, 0, 5'd9, 1, 32'h55);
        step();
        chk("add_valid", {31'h0, valid_o}, 1);
        chk("add_data", rd_data_o, 32'h55);
        chk("add_rf", {27'h0, rf_addr_o}, 9);
        chk("add_rdwe", {31'h0, rd_write_enable_o}, 1);

        // reset while waiting for read data
        drive(1, 1, 0, 3'b010, 32'h300, 0, 5'd4, 1, 32'h0);
        step();
        dmem_gnt_i = 1;
        step();
        dmem_gnt_i = 0;
        chk("rr_stall", {31'h0, stall_o}, 1);
        rst_i = 1;
        step();
        rst_i = 0;
        drive(0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        chk("rr_stall0", {31'h0, stall_o}, 0);
        chk("rr_req0", {31'h0, dmem_req_o}, 0);
        chk("rr_valid0", {31'h0, valid_o}, 0);
        dmem_rvalid_i = 1;
        dmem_rdata_i  = 32'hCAFEF00D;
        step();
        dmem_rvalid_i = 0;
        chk("rr_ign_valid", {31'h0, valid_o}, 0);
        chk("rr_ign_data", rd_data_o, 0);
        chk("rr_ign_stall", {31'h0, stall_o}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
